// File: rtl/mbox_pkg.sv
// Shared definitions for the mailbox message path: FSM encodings, CPU register
// offsets and the field positions of the {src_cpu, addr, data} FIFO word.
package mbox_pkg;

    typedef enum logic [0:0] {
        F_IDLE = 1'b0,
        F_POP  = 1'b1
    } fill_state_e;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_RD   = 2'd1,
        C_ACK  = 2'd2,
        C_DEL  = 2'd3
    } cpu_state_e;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_ADDR   = 2'd1;
    localparam logic [1:0] REG_SRC    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int SRC_WIDTH = 32;

    // Word layout is {src_cpu, addr, data}, with data in the LSBs.
    function automatic int addr_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int src_lsb(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    function automatic int word_width(input int addr_w, input int data_w);
        return SRC_WIDTH + addr_w + data_w;
    endfunction

endpackage

// File: rtl/mbox_slot.sv
// One-entry message holding register for a single CPU: load captures a word and
// sets valid, clear drops valid. Contents are discarded on reset.
module mbox_slot
    import mbox_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 load_i,
    input  logic                 clear_i,
    input  logic [SRC_WIDTH-1:0] src_i,
    input  logic [AW-1:0]        addr_i,
    input  logic [DW-1:0]        data_i,
    output logic                 valid_o,
    output logic [SRC_WIDTH-1:0] src_o,
    output logic [AW-1:0]        addr_o,
    output logic [DW-1:0]        data_o
);

    logic                 valid_q, valid_d;
    logic [SRC_WIDTH-1:0] src_q, src_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [DW-1:0]        data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        src_d   = src_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            src_d   = src_i;
            addr_d  = addr_i;
            data_d  = data_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            src_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            src_q   <= src_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign src_o   = src_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Consumer side of the mailbox message FIFO: routes popped words into per-CPU
// slots, raises irq per full slot and serves CPU reads over the req/ack bus.
module fifo_rd_ctrl
    import mbox_pkg::*;
#(
    parameter int W_WIDTH_SYS = 32,
    parameter int WIDTH_ADDR  = 32,
    parameter int N_NUMB_CPU  = 4,
    parameter int FIFO_DATA   = 32 + WIDTH_ADDR + W_WIDTH_SYS,
    parameter int DST_LSB     = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [FIFO_DATA-1:0]   m_tdata_i,
    input  logic                   m_tvalid_i,
    output logic                   m_tready_o,
    input  logic                   req_i,
    input  logic [WIDTH_ADDR-1:0]  addr_i,
    input  logic                   wren_i,
    input  logic [31:0]            numb_cpu_i,
    output logic [W_WIDTH_SYS-1:0] rdata_o,
    output logic [N_NUMB_CPU-1:0]  ack_o,
    output logic [N_NUMB_CPU-1:0]  irq_o,
    output logic                   err_bad_dst_o,
    output logic                   stall_o
);

    localparam int IDX_W    = $clog2(N_NUMB_CPU);
    localparam int ADDR_LSB = addr_lsb(W_WIDTH_SYS);
    localparam int SRC_LSB  = src_lsb(WIDTH_ADDR, W_WIDTH_SYS);

    // Head word fields
    logic [W_WIDTH_SYS-1:0] head_data;
    logic [WIDTH_ADDR-1:0]  head_addr;
    logic [SRC_WIDTH-1:0]   head_src;
    logic [WIDTH_ADDR-1:0]  dst_full;
    logic [IDX_W-1:0]       dst_idx;
    logic                   head_bad;
    logic                   head_blocked;

    assign head_data = m_tdata_i[W_WIDTH_SYS-1:0];
    assign head_addr = m_tdata_i[ADDR_LSB +: WIDTH_ADDR];
    assign head_src  = m_tdata_i[SRC_LSB +: SRC_WIDTH];

    // The whole field above DST_LSB is compared so out-of-range targets are
    // caught even when the slot index alone would alias onto a real CPU.
    assign dst_full = head_addr >> DST_LSB;
    assign dst_idx  = dst_full[IDX_W-1:0];
    assign head_bad = (dst_full >= WIDTH_ADDR'(N_NUMB_CPU));

    // Slot array
    logic [N_NUMB_CPU-1:0]  slot_valid;
    logic [N_NUMB_CPU-1:0]  load_vec;
    logic [N_NUMB_CPU-1:0]  clear_vec;
    logic [SRC_WIDTH-1:0]   slot_src  [N_NUMB_CPU];
    logic [WIDTH_ADDR-1:0]  slot_addr [N_NUMB_CPU];
    logic [W_WIDTH_SYS-1:0] slot_data [N_NUMB_CPU];

    for (genvar g = 0; g < N_NUMB_CPU; g++) begin : g_slot
        mbox_slot #(
            .DW (W_WIDTH_SYS),
            .AW (WIDTH_ADDR)
        ) u_slot (
            .clk     (clk),
            .rstn    (rstn),
            .load_i  (load_vec[g]),
            .clear_i (clear_vec[g]),
            .src_i   (head_src),
            .addr_i  (head_addr),
            .data_i  (head_data),
            .valid_o (slot_valid[g]),
            .src_o   (slot_src[g]),
            .addr_o  (slot_addr[g]),
            .data_o  (slot_data[g])
        );
    end

    assign head_blocked = !head_bad && slot_valid[dst_idx];

    // Fill FSM
    fill_state_e fill_state_q, fill_state_d;
    logic        stall_q, stall_d;
    logic        err_q, err_d;
    logic        pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill_state_q <= F_IDLE;
        end else begin
            fill_state_q <= fill_state_d;
        end
    end

    always_comb begin
        fill_state_d = fill_state_q;
        case (fill_state_q)
            F_IDLE:  if (m_tvalid_i && !head_blocked) fill_state_d = F_POP;
            F_POP:   fill_state_d = F_IDLE;
            default: fill_state_d = F_IDLE;
        endcase
    end

    // Pop is gated by rstn so the strobe stays low while reset is held.
    always_comb begin
        pop      = 1'b0;
        load_vec = '0;
        stall_d  = 1'b0;
        err_d    = 1'b0;
        if (fill_state_q == F_IDLE && m_tvalid_i && rstn) begin
            if (head_blocked) begin
                stall_d = 1'b1;
            end else begin
                pop   = 1'b1;
                err_d = head_bad;
                if (!head_bad) load_vec[dst_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign m_tready_o    = pop;
    assign stall_o       = stall_q;
    assign err_bad_dst_o = err_q;
    assign irq_o         = slot_valid;

    // CPU FSM
    cpu_state_e             cpu_state_q, cpu_state_d;
    logic [IDX_W-1:0]       cpu_idx_q, cpu_idx_d;
    logic [1:0]             ack_cnt_q, ack_cnt_d;
    logic                   clr_q, clr_d;
    logic [W_WIDTH_SYS-1:0] rdata_q, rdata_d;
    logic [W_WIDTH_SYS-1:0] rd_mux;
    logic [1:0]             reg_sel;
    logic                   req_ok;
    logic                   unused_addr_bits;

    assign reg_sel          = addr_i[3:2];
    assign req_ok           = (numb_cpu_i < 32'(N_NUMB_CPU));
    assign unused_addr_bits = ^{addr_i[WIDTH_ADDR-1:4], addr_i[1:0]};

    always_comb begin
        rd_mux = '0;
        if (!wren_i && slot_valid[cpu_idx_q]) begin
            case (reg_sel)
                REG_DATA:   rd_mux = slot_data[cpu_idx_q];
                REG_ADDR:   rd_mux = W_WIDTH_SYS'(slot_addr[cpu_idx_q]);
                REG_SRC:    rd_mux = W_WIDTH_SYS'(slot_src[cpu_idx_q]);
                REG_STATUS: rd_mux = {{(W_WIDTH_SYS-1){1'b0}}, 1'b1};
                default:    rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cpu_state_q <= C_IDLE;
            cpu_idx_q   <= '0;
            ack_cnt_q   <= '0;
            clr_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            cpu_state_q <= cpu_state_d;
            cpu_idx_q   <= cpu_idx_d;
            ack_cnt_q   <= ack_cnt_d;
            clr_q       <= clr_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        cpu_state_d = cpu_state_q;
        case (cpu_state_q)
            C_IDLE:  if (req_i && req_ok) cpu_state_d = C_RD;
            C_RD:    cpu_state_d = C_ACK;
            C_ACK:   cpu_state_d = C_DEL;
            C_DEL:   if (ack_cnt_q == 2'd0 && !req_i) cpu_state_d = C_IDLE;
            default: cpu_state_d = C_IDLE;
        endcase
    end

    // Ack spans C_ACK plus three C_DEL cycles; the counter wraps to 0 and parks.
    always_comb begin
        cpu_idx_d = cpu_idx_q;
        ack_cnt_d = ack_cnt_q;
        clr_d     = clr_q;
        rdata_d   = rdata_q;
        ack_o     = '0;
        clear_vec = '0;
        case (cpu_state_q)
            C_IDLE: begin
                cpu_idx_d = numb_cpu_i[IDX_W-1:0];
            end
            C_RD: begin
                rdata_d = rd_mux;
                clr_d   = !wren_i && (reg_sel == REG_DATA) && slot_valid[cpu_idx_q];
            end
            C_ACK: begin
                ack_o[cpu_idx_q]     = 1'b1;
                clear_vec[cpu_idx_q] = clr_q;
                ack_cnt_d            = 2'd1;
            end
            C_DEL: begin
                ack_o[cpu_idx_q] = (ack_cnt_q != 2'd0);
                if (ack_cnt_q != 2'd0) ack_cnt_d = ack_cnt_q + 2'd1;
            end
            default: ;
        endcase
    end

    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: a queue-backed FIFO source, CPU bus read task
// and hand-computed expectations for fill, stall, bad-dst, reads and reset.
module tb_fifo_rd_ctrl;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int N  = 4;
    localparam int FD = 32 + AW + DW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [FD-1:0] m_tdata_i = '0;
    logic          m_tvalid_i = 1'b0;
    logic          m_tready_o;
    logic          req_i = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic          wren_i = 1'b0;
    logic [31:0]   numb_cpu_i = '0;
    logic [DW-1:0] rdata_o;
    logic [N-1:0]  ack_o;
    logic [N-1:0]  irq_o;
    logic          err_bad_dst_o;
    logic          stall_o;

    always #5 clk = ~clk;

    fifo_rd_ctrl #(
        .W_WIDTH_SYS (DW),
        .WIDTH_ADDR  (AW),
        .N_NUMB_CPU  (N),
        .FIFO_DATA   (FD),
        .DST_LSB     (0)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .m_tdata_i     (m_tdata_i),
        .m_tvalid_i    (m_tvalid_i),
        .m_tready_o    (m_tready_o),
        .req_i         (req_i),
        .addr_i        (addr_i),
        .wren_i        (wren_i),
        .numb_cpu_i    (numb_cpu_i),
        .rdata_o       (rdata_o),
        .ack_o         (ack_o),
        .irq_o         (irq_o),
        .err_bad_dst_o (err_bad_dst_o),
        .stall_o       (stall_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // FIFO source: head presented at negedge, handshake sampled just before posedge.
    logic [FD-1:0] fifo_q[$];
    int   pop_count = 0;
    int   rdy_cycles = 0;
    int   err_cycles = 0;
    int   cyc = 0;
    int   last_pop_cyc = 0;
    logic pend = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (pend) begin
            void'(fifo_q.pop_front());
            pop_count++;
            last_pop_cyc = cyc;
        end
        m_tvalid_i = (fifo_q.size() > 0);
        m_tdata_i  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        if (err_bad_dst_o) err_cycles++;
        #4;
        if (m_tready_o) begin
            rdy_cycles++;
            chk("rdy_wo_vld", m_tvalid_i, 1);
        end
        pend = m_tvalid_i && m_tready_o;
    end

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    function automatic logic [FD-1:0] word(input logic [31:0] src, input logic [31:0] addr,
                                           input logic [31:0] data);
        return {src, addr, data};
    endfunction

    task automatic wait_pops(input string tag, input int n);
        for (int i = 0; i < 12; i++) begin
            if (pop_count >= n) break;
            step();
        end
        chk(tag, pop_count, n);
    endtask

    task automatic cpu_rd(input int cpu, input logic [1:0] sel, input logic wr,
                          input int hold_extra, output logic [31:0] rd, output int lat,
                          output int len, output logic [3:0] ack_vec, output int extra_acks,
                          output int ack_cyc);
        req_i      = 1'b1;
        numb_cpu_i = cpu;
        addr_i     = {28'h0, sel, 2'b00};
        wren_i     = wr;
        lat = 0; len = 0; rd = '0; ack_vec = '0; extra_acks = 0; ack_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            lat++;
            if (ack_o[cpu]) break;
        end
        if (ack_o[cpu]) begin
            rd      = rdata_o;
            ack_vec = ack_o;
            ack_cyc = cyc;
            len     = 1;
            for (int i = 0; i < 8; i++) begin
                step();
                if (!ack_o[cpu]) break;
                len++;
            end
        end
        for (int i = 0; i < hold_extra; i++) begin
            step();
            if (ack_o != '0) extra_acks++;
        end
        req_i  = 1'b0;
        wren_i = 1'b0;
        step();
        step();
    endtask

    logic [31:0] rd;
    logic [3:0]  av;
    int          lat, len, extra, ack_cyc, acks;

    initial begin
        // Reset state
        step(); step(); step();
        chk("rst_tready", m_tready_o, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_err", err_bad_dst_o, 0);
        chk("rst_stall", stall_o, 0);
        rstn = 1'b1;
        step();

        // Single word to CPU2, then CPU2 DATA read
        fifo_q.push_back(word(32'd1, 32'd2, 32'hA5A5_0001));
        wait_pops("t1_pop", 1);
        chk("t1_irq", irq_o, 4'b0100);
        step(); step(); step();
        chk("t1_rdy_pulses", rdy_cycles, 1);
        chk("t1_no_err", err_cycles, 0);
        cpu_rd(2, 2'd0, 1'b0, 0, rd, lat, len, av, extra, ack_cyc);
        chk("t1_rdata", rd, 32'hA5A5_0001);
        chk("t1_lat", lat, 2);
        chk("t1_ack_len", len, 4);
        chk("t1_ack_vec", av, 4'b0100);
        chk("t1_irq_clr", irq_o, 4'b0000);
        chk("t1_rdata_hold", rdata_o, 32'hA5A5_0001);

        // Back-to-back words to CPU3: second blocks until the slot is read
        fifo_q.push_back(word(32'd0, 32'd3, 32'h3333_0001));
        fifo_q.push_back(word(32'd0, 32'd3, 32'h3333_0002));
        wait_pops("t2_pop1", 2);
        step(); step(); step(); step();
        chk("t2_blocked", pop_count, 2);
        chk("t2_stall", stall_o, 1);
        chk("t2_tready", m_tready_o, 0);
        chk("t2_irq", irq_o, 4'b1000);
        cpu_rd(3, 2'd0, 1'b0, 0, rd, lat, len, av, extra, ack_cyc);
        chk("t2_rdata1", rd, 32'h3333_0001);
        chk("t2_refilled", pop_count, 3);
        chk("t2_refill_lat", (last_pop_cyc - ack_cyc >= 0) && (last_pop_cyc - ack_cyc <= 3), 1);
        chk("t2_stall_clr", stall_o, 0);
        chk("t2_irq_refill", irq_o, 4'b1000);
        cpu_rd(3, 2'd0, 1'b0, 0, rd, lat, len, av, extra, ack_cyc);
        chk("t2_rdata2", rd, 32'h3333_0002);
        chk("t2_irq_empty", irq_o, 4'b0000);

        // Out-of-range destination is popped and dropped
        fifo_q.push_back(word(32'd7, 32'd5, 32'hDEAD_BEEF));
        wait_pops("t3_pop", 4);
        step(); step(); step();
        chk("t3_err_len", err_cycles, 1);
        chk("t3_irq", irq_o, 4'b0000);
        chk("t3_stall", stall_o, 0);

        // Non-destructive register reads of a full slot
        fifo_q.push_back(word(32'h0000_00C3, 32'd1, 32'h1111_2222));
        wait_pops("t4_pop", 5);
        step();
        chk("t4_irq", irq_o, 4'b0010);
        cpu_rd(1, 2'd3, 1'b0, 0, rd, lat, len, av, extra, ack_cyc);
        chk("t4_status", rd, 32'd1);
        chk("t4_status_len", len, 4);
        cpu_rd(1, 2'd1, 1'b0, 0, rd, lat, len, av, extra, ack_cyc);
        chk("t4_addr", rd, 32'd1);
        cpu_rd(1, 2'd2, 1'b0, 0, rd, lat, len, av, extra, ack_cyc);
        chk("t4_src", rd, 32'h0000_00C3);
        chk("t4_irq_kept", irq_o, 4'b0010);

        // Write is acked only; req held past ack gives no second ack
        cpu_rd(0, 2'd0, 1'b1, 3, rd, lat, len, av, extra, ack_cyc);
        chk("t5_wr_rdata", rd, 32'd0);
        chk("t5_wr_len", len, 4);
        chk("t5_wr_ack_vec", av, 4'b0001);
        chk("t5_no_2nd_ack", extra, 0);
        chk("t5_slots_kept", irq_o, 4'b0010);
        cpu_rd(0, 2'd0, 1'b0, 0, rd, lat, len, av, extra, ack_cyc);
        chk("t5_empty_rd", rd, 32'd0);
        chk("t5_empty_lat", lat, 2);

        // Request from a non-existent CPU is ignored
        req_i = 1'b1; numb_cpu_i = 32'd6; addr_i = '0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ack_o != '0) acks++;
        end
        req_i = 1'b0;
        step(); step();
        chk("t5_bad_cpu_ack", acks, 0);
        cpu_rd(2, 2'd3, 1'b0, 0, rd, lat, len, av, extra, ack_cyc);
        chk("t5_after_bad_lat", lat, 2);
        chk("t5_after_bad_rd", rd, 32'd0);

        // Asynchronous reset during an ack with slot 1 full
        req_i = 1'b1; numb_cpu_i = 32'd1; addr_i = {28'h0, 2'd3, 2'b00}; wren_i = 1'b0;
        step(); step();
        chk("t6_ack_before", ack_o, 4'b0010);
        chk("t6_rdata_before", rdata_o, 32'd1);
        rstn = 1'b0;
        #1;
        chk("t6_rst_ack", ack_o, 0);
        chk("t6_rst_irq", irq_o, 0);
        chk("t6_rst_rdata", rdata_o, 0);
        chk("t6_rst_tready", m_tready_o, 0);
        chk("t6_rst_stall", stall_o, 0);
        chk("t6_rst_err", err_bad_dst_o, 0);
        req_i = 1'b0;
        fifo_q.push_back(word(32'd4, 32'd1, 32'h5A5A_1234));
        step(); step();
        chk("t6_held_no_pop", pop_count, 5);
        rstn = 1'b1;
        wait_pops("t6_pop", 6);
        step();
        chk("t6_irq", irq_o, 4'b0010);
        cpu_rd(1, 2'd0, 1'b0, 0, rd, lat, len, av, extra, ack_cyc);
        chk("t6_rdata", rd, 32'h5A5A_1234);
        chk("t6_irq_clr", irq_o, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
